// File: rtl/priority_encoder_pkg.sv
// Shared mode encodings for the priority encoder arbiter.
package priority_encoder_pkg;

  localparam logic [1:0] MODE_LOW  = 2'b00;
  localparam logic [1:0] MODE_HIGH = 2'b01;
  localparam logic [1:0] MODE_RR   = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    PRIO_LOW  = MODE_LOW,
    PRIO_HIGH = MODE_HIGH,
    PRIO_RR   = MODE_RR,
    PRIO_RSVD = MODE_RSVD
  } mode_e;

endpackage

// File: rtl/priority_encoder_search.sv
// Combinational circular search for the first set request from a start index.
module priority_encoder_search #(
  parameter int unsigned NUM_INPUTS = 8,
  localparam int unsigned INDEX_WIDTH = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0]  req,
  input  logic [INDEX_WIDTH-1:0] start,
  input  logic                   dir_up,
  output logic                   found,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   multiple
);

  int unsigned             pos;
  logic [INDEX_WIDTH-1:0]  pos_idx;

  // Walk offsets 0..N-1 from start, wrapping modulo N in either direction.
  always_comb begin
    found   = 1'b0;
    index   = '0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (dir_up) begin
        pos = (32'(start) + k) % NUM_INPUTS;
      end else begin
        pos = (32'(start) + NUM_INPUTS - k) % NUM_INPUTS;
      end
      pos_idx = INDEX_WIDTH'(pos);
      if (!found && req[pos_idx]) begin
        found = 1'b1;
        index = pos_idx;
      end
    end
  end

  assign multiple = ($countones(req) > 1);

endmodule

// File: rtl/priority_encoder_arbiter.sv
// Registered N-input priority encoder with fixed/round-robin modes and a valid/ready stage.
module priority_encoder_arbiter
  import priority_encoder_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 8,
  localparam int unsigned INDEX_WIDTH = $clog2(NUM_INPUTS)
) (
  input  logic                   Clock_In,
  input  logic                   Reset_In,
  input  logic                   Enable_In,
  input  logic [1:0]             Mode_In,
  input  logic [NUM_INPUTS-1:0]  Data_In,
  input  logic                   Ready_In,
  output logic [INDEX_WIDTH-1:0] Encoded_Value_Out,
  output logic                   Valid_Out,
  output logic                   Multiple_Out
);

  mode_e                   mode_sel;
  logic [INDEX_WIDTH-1:0]  rr_ptr;
  logic [INDEX_WIDTH-1:0]  rr_ptr_next;
  logic [INDEX_WIDTH-1:0]  start;
  logic                    dir_up;
  logic                    found;
  logic [INDEX_WIDTH-1:0]  sel_index;
  logic                    sel_multiple;
  logic                    stage_free;
  logic                    load;

  assign mode_sel = mode_e'(Mode_In);

  // Fixed-high scans up from 0, round-robin up from the pointer, low/reserved down from N-1.
  always_comb begin
    start  = '0;
    dir_up = 1'b0;
    case (mode_sel)
      PRIO_HIGH: begin
        start  = '0;
        dir_up = 1'b1;
      end
      PRIO_RR: begin
        start  = rr_ptr;
        dir_up = 1'b1;
      end
      default: begin
        start  = INDEX_WIDTH'(NUM_INPUTS - 1);
        dir_up = 1'b0;
      end
    endcase
  end

  priority_encoder_search #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_search (
    .req      (Data_In),
    .start    (start),
    .dir_up   (dir_up),
    .found    (found),
    .index    (sel_index),
    .multiple (sel_multiple)
  );

  assign stage_free  = !Valid_Out || Ready_In;
  assign load        = Enable_In && found && stage_free;
  assign rr_ptr_next = (sel_index == INDEX_WIDTH'(NUM_INPUTS - 1)) ?
                       '0 : sel_index + INDEX_WIDTH'(1);

  always_ff @(posedge Clock_In) begin
    if (!Reset_In) begin
      Encoded_Value_Out <= '0;
      Valid_Out         <= 1'b0;
      Multiple_Out      <= 1'b0;
      rr_ptr            <= '0;
    end else if (stage_free) begin
      if (load) begin
        Encoded_Value_Out <= sel_index;
        Valid_Out         <= 1'b1;
        Multiple_Out      <= sel_multiple;
        if (mode_sel == PRIO_RR) begin
          rr_ptr <= rr_ptr_next;
        end
      end else begin
        Valid_Out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_priority_encoder_arbiter.sv
// Scoreboard bench for priority_encoder_arbiter (N=8 main instance, N=5 wrap instance).
module tb_priority_encoder_arbiter;

  typedef struct packed {
    logic [2:0] idx;
    logic       mult;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] mode;
  logic [7:0] data;
  logic       ready;
  logic [2:0] enc;
  logic       valid;
  logic       multiple;

  logic       enable5;
  logic [1:0] mode5;
  logic [4:0] data5;
  logic       ready5;
  logic [2:0] enc5;
  logic       valid5;
  logic       multiple5;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic m_valid;
  int   m_ptr;

  always #5 clk = ~clk;

  priority_encoder_arbiter #(.NUM_INPUTS(8)) dut (
    .Clock_In          (clk),
    .Reset_In          (rst_n),
    .Enable_In         (enable),
    .Mode_In           (mode),
    .Data_In           (data),
    .Ready_In          (ready),
    .Encoded_Value_Out (enc),
    .Valid_Out         (valid),
    .Multiple_Out      (multiple)
  );

  priority_encoder_arbiter #(.NUM_INPUTS(5)) dut5 (
    .Clock_In          (clk),
    .Reset_In          (rst_n),
    .Enable_In         (enable5),
    .Mode_In           (mode5),
    .Data_In           (data5),
    .Ready_In          (ready5),
    .Encoded_Value_Out (enc5),
    .Valid_Out         (valid5),
    .Multiple_Out      (multiple5)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_sel(input logic [7:0] d, input logic [1:0] m, input int ptr);
    int i;
    if (m == 2'b01) begin
      for (int k = 0; k < 8; k++) if (d[k]) return k;
    end else if (m == 2'b10) begin
      for (int k = 0; k < 8; k++) begin
        i = (ptr + k) % 8;
        if (d[i]) return i;
      end
    end else begin
      for (int k = 7; k >= 0; k--) if (d[k]) return k;
    end
    return -1;
  endfunction

  // Drive one cycle, predict the load, push the expected result, then check Valid_Out.
  task automatic cycle(input logic a_rst, input logic a_en, input logic [1:0] a_mode,
                       input logic [7:0] a_data, input logic a_rdy);
    int   idx;
    logic free;
    exp_t e;
    rst_n  = a_rst;
    enable = a_en;
    mode   = a_mode;
    data   = a_data;
    ready  = a_rdy;
    if (!a_rst) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      sb.delete();
    end else begin
      free = !m_valid || a_rdy;
      if (a_en && a_data != 8'h00 && free) begin
        idx    = model_sel(a_data, a_mode, m_ptr);
        e.idx  = 3'(idx);
        e.mult = ($countones(a_data) > 1);
        sb.push_back(e);
        m_valid = 1'b1;
        if (a_mode == 2'b10) m_ptr = (idx + 1) % 8;
      end else if (free) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("valid", int'(valid), int'(m_valid));
  endtask

  // Pop and compare on every transfer edge of the main instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid && ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_index", int'(enc), int'(e.idx));
        chk("sb_multiple", int'(multiple), int'(e.mult));
      end
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; mode = 2'b00; data = 8'h00; ready = 1'b0;
    enable5 = 1'b0; mode5 = 2'b10; data5 = 5'b0; ready5 = 1'b1;
    m_valid = 1'b0; m_ptr = 0;

    // Reset held two edges with all requests asserted
    cycle(1'b0, 1'b1, 2'b10, 8'hFF, 1'b1);
    cycle(1'b0, 1'b1, 2'b10, 8'hFF, 1'b1);
    chk("rst_valid", int'(valid), 0);
    chk("rst_enc", int'(enc), 0);
    chk("rst_mult", int'(multiple), 0);
    cycle(1'b1, 1'b1, 2'b10, 8'hFF, 1'b1);
    chk("rr_first", int'(enc), 0);

    // Fixed modes
    cycle(1'b1, 1'b1, 2'b00, 8'b0010_0110, 1'b1);
    chk("mode00", int'(enc), 5);
    chk("mode00_mult", int'(multiple), 1);
    cycle(1'b1, 1'b1, 2'b01, 8'b0010_0110, 1'b1);
    chk("mode01", int'(enc), 1);
    cycle(1'b1, 1'b1, 2'b11, 8'b0010_0110, 1'b1);
    chk("mode11", int'(enc), 5);

    // Round-robin from a fresh pointer
    cycle(1'b0, 1'b0, 2'b10, 8'h00, 1'b1);
    cycle(1'b1, 1'b1, 2'b10, 8'b1000_0001, 1'b1);
    chk("rr_seq0", int'(enc), 0);
    cycle(1'b1, 1'b1, 2'b10, 8'b1000_0001, 1'b1);
    chk("rr_seq1", int'(enc), 7);
    cycle(1'b1, 1'b1, 2'b10, 8'b1000_0001, 1'b1);
    chk("rr_seq2", int'(enc), 0);
    cycle(1'b1, 1'b1, 2'b10, 8'b1000_0001, 1'b1);
    chk("rr_seq3", int'(enc), 7);
    cycle(1'b1, 1'b1, 2'b10, 8'h10, 1'b1);
    chk("rr_single", int'(enc), 4);
    chk("rr_single_mult", int'(multiple), 0);

    // Backpressure
    cycle(1'b1, 1'b1, 2'b00, 8'h04, 1'b1);
    chk("bp_load", int'(enc), 2);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 2'b00, 8'h80, 1'b0);
      chk("bp_hold", int'(enc), 2);
    end
    cycle(1'b1, 1'b1, 2'b00, 8'h80, 1'b1);
    chk("bp_release", int'(enc), 7);

    // Idle after transfer: valid drops, value held
    cycle(1'b1, 1'b1, 2'b00, 8'h00, 1'b1);
    chk("idle_data0", int'(enc), 7);
    cycle(1'b1, 1'b0, 2'b00, 8'hFF, 1'b1);
    chk("idle_en0", int'(enc), 7);

    // Reset mid-stall clears the round-robin pointer
    cycle(1'b1, 1'b1, 2'b10, 8'h40, 1'b1);
    chk("rr_ptr_set", int'(enc), 6);
    cycle(1'b1, 1'b1, 2'b00, 8'h02, 1'b0);
    chk("stall_hold", int'(enc), 6);
    cycle(1'b0, 1'b1, 2'b00, 8'h02, 1'b0);
    chk("midstall_rst_valid", int'(valid), 0);
    cycle(1'b1, 1'b1, 2'b10, 8'b1000_0001, 1'b1);
    chk("rr_after_rst", int'(enc), 0);

    // N=5 round-robin wrap 4 -> 0
    enable5 = 1'b1; data5 = 5'b10001;
    cycle(1'b1, 1'b0, 2'b00, 8'h00, 1'b1);
    chk("n5_seq0", int'(enc5), 0);
    chk("n5_valid", int'(valid5), 1);
    cycle(1'b1, 1'b0, 2'b00, 8'h00, 1'b1);
    chk("n5_seq1", int'(enc5), 4);
    cycle(1'b1, 1'b0, 2'b00, 8'h00, 1'b1);
    chk("n5_seq2", int'(enc5), 0);
    enable5 = 1'b0;

    cycle(1'b1, 1'b0, 2'b00, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 2'b00, 8'h00, 1'b1);
    chk("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
